// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> multiply/divide unit signal bundle.
// The pipeline side uses the master modport; the MDU controller uses slave.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_mdu;
  logic        busy;
  logic        stall_mdu;
  logic        done;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mdu_op, rs_data, rt_data, d_mdu,
    input  busy, stall_mdu, done, rd_data, hi, lo
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data, d_mdu,
    output busy, stall_mdu, done, rd_data, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op.
//
// state | meaning
// IDLE  | accepts mult/div (enter RUN) and mthi/mtlo (direct write)
// RUN   | counting down cnt; commits HI/LO at the edge ending cnt==1
module mdu_ctrl (
  input  logic      clk,
  input  logic      reset,
`ifdef MDU_CANCEL_EN
  input  logic      cancel,
`endif
  mdu_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic        latch, commit, wr_hi, wr_lo;
  logic        cancel_i;
  logic        start_md;

`ifdef MDU_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  assign start_md = bus.start && (bus.mdu_op >= 4'd1) && (bus.mdu_op <= 4'd4);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !cancel_i) begin
          if (start_md) begin
            latch     = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = (bus.mdu_op <= 4'd2) ? 4'd5 : 4'd10;
          end else if (bus.mdu_op == 4'd5) begin
            wr_hi = 1'b1;
          end else if (bus.mdu_op == 4'd6) begin
            wr_lo = 1'b1;
          end
        end
      end
      RUN: begin
        if (cancel_i) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd1) begin
          commit    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result datapath works from the latched operands, so it is stable for all of RUN.
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, dvd, dvs, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  always_comb begin
    abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
    dvd    = (op_q == 4'd3) ? abs_a : a_q;
    dvs    = (op_q == 4'd3) ? abs_b : b_q;
    if (dvs == 32'd0) dvs = 32'd1;
    q_mag  = dvd / dvs;
    r_mag  = dvd % dvs;
    prod   = 64'd0;
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      4'd1: begin
        prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_we = 1'b1;
      end
      4'd2: begin
        prod   = {32'd0, a_q} * {32'd0, b_q};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_we = 1'b1;
      end
      4'd3: begin
        // Magnitude divide then re-sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        res_lo = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        res_hi = a_q[31] ? (~r_mag + 32'd1) : r_mag;
        res_we = (b_q != 32'd0);
      end
      4'd4: begin
        res_lo = q_mag;
        res_hi = r_mag;
        res_we = (b_q != 32'd0);
      end
      default: res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      done_q <= 1'b0;
      op_q   <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      cnt    <= cnt_nxt;
      done_q <= commit;
      if (latch) begin
        op_q <= bus.mdu_op;
        a_q  <= bus.rs_data;
        b_q  <= bus.rt_data;
      end
      if (commit && res_we) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (wr_hi) hi_q <= bus.rs_data;
      if (wr_lo) lo_q <= bus.rs_data;
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_mdu = bus.d_mdu & ((state == RUN) | start_md);
  assign bus.rd_data   = (bus.mdu_op == 4'd7) ? hi_q :
                         (bus.mdu_op == 4'd8) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: random mult/div traffic against an arithmetic HI/LO model.
// Define MDU_CANCEL_EN on both RTL and bench to exercise the cancel path.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef MDU_CANCEL_EN
  logic cancel = 1'b0;
`endif
  mdu_ctrl_if bus ();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Reference: architectural effect of each op on HI/LO.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up, ua, ub;
    int              sa, sb;
    case (op)
      4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); m_hi = sp[63:32]; m_lo = sp[31:0]; end
      4'd2: begin ua = a; ub = b; up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3: begin
        if (b == 0) begin end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 0; end
        else begin sa = a; sb = b; m_lo = sa / sb; m_hi = sa % sb; end
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op <= 4'd2) ? 5 : 10;
  endfunction

  // Drives one start and records what the DUT does until one cycle past done.
  task automatic issue_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic d, output int busy_n, output int done_n, output int done_at,
                          output int stall_err, output int hilo_chg, output logic stall_start);
    logic [31:0] h0, l0;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = op; bus.rs_data = a; bus.rt_data = b; bus.d_mdu = d;
    #1;
    stall_start = bus.stall_mdu;
    h0 = bus.hi; l0 = bus.lo;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 4'd0; bus.rs_data = $urandom; bus.rt_data = $urandom;
    busy_n = 0; done_n = 0; done_at = -1; stall_err = 0; hilo_chg = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (bus.busy) busy_n++;
      if (bus.busy && (bus.hi !== h0 || bus.lo !== l0)) hilo_chg++;
      if (bus.done) begin done_n++; if (done_at < 0) done_at = k; end
      if (bus.stall_mdu !== (d & bus.busy)) stall_err++;
      if (done_at >= 0 && k > done_at) break;
    end
    bus.d_mdu = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus.mdu_op = 4'd7;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.rd_data !== 32'd0)
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h rd=%h want 0/0/0/0/0",
               bus.busy, bus.done, bus.hi, bus.lo, bus.rd_data);
    else n_pass++;
    bus.mdu_op = 4'd0;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int busy_n, done_n, done_at, stall_err, hilo_chg;
    logic ss;
    issue_md(op, a, b, 1'b0, busy_n, done_n, done_at, stall_err, hilo_chg, ss);
    model(op, a, b);
    n_checks++;
    if (busy_n != exp_lat(op) || done_n != 1 || done_at != exp_lat(op) || hilo_chg != 0)
      $display("FAIL %s_timing: busy=%0d done=%0d at=%0d hilo_chg=%0d want busy=%0d done=1 at=%0d chg=0",
               name, busy_n, done_n, done_at, hilo_chg, exp_lat(op), exp_lat(op));
    else n_pass++;
    n_checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL %s_result op=%0d a=%h b=%h: hi=%h lo=%h want hi=%h lo=%h",
               name, op, a, b, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
  endtask

  task automatic test_directed();
    test_muldiv(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA)
      $display("FAIL mult_const: hi=%h lo=%h want FFFFFFFF/FFFFFFFA", bus.hi, bus.lo);
    else n_pass++;
    test_muldiv(4'd2, 32'hFFFF_FFFF, 32'd2, "multu_max");
    n_checks++;
    if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFE)
      $display("FAIL multu_const: hi=%h lo=%h want 00000001/FFFFFFFE", bus.hi, bus.lo);
    else n_pass++;
    test_muldiv(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD)
      $display("FAIL div_const: hi=%h lo=%h want FFFFFFFF/FFFFFFFD", bus.hi, bus.lo);
    else n_pass++;
    test_muldiv(4'd4, 32'd7, 32'd0, "divu_zero");
    test_muldiv(4'd3, 32'h1234_5678, 32'd0, "div_zero");
    test_muldiv(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    n_checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000)
      $display("FAIL div_ovf_const: hi=%h lo=%h want 00000000/80000000", bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
      test_muldiv(op, a, b, "rand");
    end
  endtask

  task automatic test_stall();
    int busy_n, done_n, done_at, stall_err, hilo_chg;
    logic ss;
    issue_md(4'd3, 32'd100, 32'd7, 1'b1, busy_n, done_n, done_at, stall_err, hilo_chg, ss);
    model(4'd3, 32'd100, 32'd7);
    n_checks++;
    if (ss !== 1'b1 || stall_err != 0 || busy_n != 10)
      $display("FAIL stall_div: start_stall=%b mismatches=%0d busy=%0d want 1/0/10", ss, stall_err, busy_n);
    else n_pass++;
    @(negedge clk);
    bus.d_mdu = 1'b1; bus.start = 1'b1; bus.mdu_op = 4'd8;
    #1;
    n_checks++;
    if (bus.stall_mdu !== 1'b0)
      $display("FAIL stall_mflo_idle: stall=%b want 0", bus.stall_mdu);
    else n_pass++;
    bus.d_mdu = 1'b0; bus.start = 1'b0; bus.mdu_op = 4'd0;
  endtask

  task automatic test_mtlo_mflo();
    int busy_seen = 0;
    logic [31:0] v;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 4'd6; bus.rs_data = 32'h0000_1234;
    #1; if (bus.busy) busy_seen++;
    @(negedge clk);
    bus.mdu_op = 4'd8; bus.rs_data = 32'hDEAD_BEEF;
    #1; if (bus.busy || bus.done) busy_seen++;
    m_lo = 32'h0000_1234;
    n_checks++;
    if (bus.rd_data !== 32'h0000_1234 || busy_seen != 0)
      $display("FAIL mtlo_mflo: rd=%h busy_seen=%0d want 00001234/0", bus.rd_data, busy_seen);
    else n_pass++;
    v = $urandom;
    @(negedge clk);
    bus.mdu_op = 4'd5; bus.rs_data = v;
    @(negedge clk);
    bus.mdu_op = 4'd7;
    #1;
    model(4'd5, v, 32'd0);
    n_checks++;
    if (bus.rd_data !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0)
      $display("FAIL mthi_mfhi: rd=%h lo=%h busy=%b want %h/%h/0", bus.rd_data, bus.lo, bus.busy, m_hi, m_lo);
    else n_pass++;
    bus.start = 1'b0; bus.mdu_op = 4'd0;
  endtask

  task automatic test_busy_ignore();
    int busy_n = 0, done_n = 0;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 4'd2; bus.rs_data = a; bus.rt_data = b;
    @(negedge clk);
    bus.mdu_op = 4'd5; bus.rs_data = 32'hAAAA_5555;
    @(negedge clk);
    bus.mdu_op = 4'd3; bus.rs_data = 32'd9; bus.rt_data = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 4'd0;
    model(4'd2, a, b);
    for (int k = 0; k < 14; k++) begin
      #1;
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || busy_n != 3 || done_n != 1)
      $display("FAIL busy_ignore: hi=%h lo=%h busy_tail=%0d done=%0d want %h/%h/3/1",
               bus.hi, bus.lo, busy_n, done_n, m_hi, m_lo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int guard = 0, busy_n = 0, done_n = 0;
    logic [31:0] a, b;
    a = $urandom; b = 32'($urandom_range(1, 1000));
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 4'd1; bus.rs_data = 32'hFFFF_FFF0; bus.rt_data = 32'd16;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 4'd0;
    #1;
    while (!bus.done && guard < 20) begin @(negedge clk); #1; guard++; end
    model(4'd1, 32'hFFFF_FFF0, 32'd16);
    n_checks++;
    if (guard >= 20 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL b2b_first: guard=%0d hi=%h lo=%h want hi=%h lo=%h", guard, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    bus.start = 1'b1; bus.mdu_op = 4'd4; bus.rs_data = a; bus.rt_data = b;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 4'd0;
    model(4'd4, a, b);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || busy_n != 10 || done_n != 1)
      $display("FAIL b2b_second: hi=%h lo=%h busy=%0d done=%0d want %h/%h/10/1",
               bus.hi, bus.lo, busy_n, done_n, m_hi, m_lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 4'd1; bus.rs_data = 32'd1234; bus.rt_data = 32'd5678;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.done || bus.busy) done_n++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || done_n != 0)
      $display("FAIL reset_mid: hi=%h lo=%h busy_or_done=%0d want 0/0/0", bus.hi, bus.lo, done_n);
    else n_pass++;
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    int act = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 4'd5; bus.rs_data = 32'h1111_2222;
    @(negedge clk);
    bus.mdu_op = 4'd6; bus.rs_data = 32'h3333_4444;
    @(negedge clk);
    model(4'd5, 32'h1111_2222, 0); model(4'd6, 32'h3333_4444, 0);
    bus.mdu_op = 4'd1; bus.rs_data = 32'd77; bus.rt_data = 32'd99;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 4'd0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.busy || bus.done) act++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || act != 0)
      $display("FAIL cancel_run: hi=%h lo=%h activity=%0d want %h/%h/0", bus.hi, bus.lo, act, m_hi, m_lo);
    else n_pass++;
    act = 0;
    bus.start = 1'b1; bus.mdu_op = 4'd3; bus.rs_data = 32'd50; bus.rt_data = 32'd3; cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 4'd0; cancel = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus.busy || bus.done) act++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || act != 0)
      $display("FAIL cancel_start: hi=%h lo=%h activity=%0d want %h/%h/0", bus.hi, bus.lo, act, m_hi, m_lo);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.mdu_op = 4'd0; bus.rs_data = 32'd0; bus.rt_data = 32'd0; bus.d_mdu = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_mtlo_mflo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
